// File: rtl/uart_tx_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_tx_arb_pkg;

  localparam int BYTE_W      = 8;
  localparam int NUM_REQ_MAX = 8;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    WRITE = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bundle of requester lanes and transmitter write-port signals around the arbiter.
// The slave modport is the arbiter's view; the master modport is the producer/transmitter side.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import uart_tx_arb_pkg::*;

  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ*BYTE_W-1:0] req_data_i;
  logic [NUM_REQ-1:0]        req_last_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic                      data_buffer_full_i;
  logic [BYTE_W-1:0]         data_o;
  logic                      data_write_o;
  logic [NUM_REQ-1:0]        grant_o;
  logic                      busy_o;

  modport slave (
    input  req_valid_i,
    input  req_data_i,
    input  req_last_i,
    input  data_buffer_full_i,
    output req_ready_o,
    output data_o,
    output data_write_o,
    output grant_o,
    output busy_o
  );

  modport master (
    output req_valid_i,
    output req_data_i,
    output req_last_i,
    output data_buffer_full_i,
    input  req_ready_o,
    input  data_o,
    input  data_write_o,
    input  grant_o,
    input  busy_o
  );

endinterface

// File: rtl/uart_tx_rr_pick.sv
// Combinational round-robin selector: first set bit of req_i at or after ptr_i, wrapping.
module uart_tx_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [PTR_W-1:0]   idx_o,
  output logic               valid_o
);

  logic [PTR_W:0]   cand;
  logic [PTR_W-1:0] sel;

  // Scan from the farthest offset back toward ptr so the closest requester is written last and wins
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    sel     = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      cand = {1'b0, ptr_i} + (PTR_W+1)'(off);
      if (cand >= (PTR_W+1)'(NUM_REQ)) begin
        cand = cand - (PTR_W+1)'(NUM_REQ);
      end
      sel = cand[PTR_W-1:0];
      if (req_i[sel]) begin
        grant_o      = '0;
        grant_o[sel] = 1'b1;
        idx_o        = sel;
        valid_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter write port among NUM_REQ byte producers.
// Each accepted byte produces one write pulse, followed by a gap cycle so the transmitter's
// full flag can catch up before the next arbitration.
// Optional feature: define UART_TX_ARB_LOCK_EN to keep multi-byte packets contiguous.
// NUM_REQ is expected to lie in 2..NUM_REQ_MAX.
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input logic              clock,
  input logic              reset_i,
  uart_tx_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(NUM_REQ);

  localparam logic [1:0] ST_ARB   = ARB;
  localparam logic [1:0] ST_WRITE = WRITE;
  localparam logic [1:0] ST_GAP   = GAP;

  logic [1:0]         state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [BYTE_W-1:0]  data_q, data_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] winOnehot;
  logic [PTR_W-1:0]   winIdx;
  logic               winValid;
  logic               accept;
  logic               winLast;
  logic [PTR_W-1:0]   ptrAfterWin;
  logic [BYTE_W-1:0]  laneData;
  logic               lockHeld;

`ifdef UART_TX_ARB_LOCK_EN
  logic lock_q, lock_d;

  assign lockHeld = lock_q;
  // While a packet is in progress only its owner (kept in grant_q) may compete
  assign eligible = lock_q ? (bus.req_valid_i & grant_q) : bus.req_valid_i;
`else
  assign lockHeld = 1'b0;
  assign eligible = bus.req_valid_i;
`endif

  uart_tx_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req_i   (eligible),
    .ptr_i   (ptr_q),
    .grant_o (winOnehot),
    .idx_o   (winIdx),
    .valid_o (winValid)
  );

  // A byte is taken only while arbitrating, with room downstream, and never during reset
  assign accept      = (state_q == ST_ARB) && !reset_i && !bus.data_buffer_full_i && winValid;
  assign ptrAfterWin = (winIdx == PTR_W'(NUM_REQ - 1)) ? '0 : winIdx + 1'b1;
  assign winLast     = |(bus.req_last_i & winOnehot);

  // Steer the winning lane's byte using the one-hot winner, avoiding a variable part-select
  always_comb begin
    laneData = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winOnehot[i]) begin
        laneData = laneData | bus.req_data_i[i*BYTE_W +: BYTE_W];
      end
    end
  end

  // Next-state logic for the ARB -> WRITE -> GAP cycle plus pointer, data, grant and lock
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    grant_d = grant_q;
`ifdef UART_TX_ARB_LOCK_EN
    lock_d  = lock_q;
`endif
    case (state_q)
      ST_ARB: begin
        if (accept) begin
          data_d  = laneData;
          grant_d = winOnehot;
          state_d = ST_WRITE;
`ifdef UART_TX_ARB_LOCK_EN
          if (winLast) begin
            lock_d = 1'b0;
            ptr_d  = ptrAfterWin;
          end else begin
            lock_d = 1'b1;
          end
`else
          ptr_d   = ptrAfterWin;
`endif
        end
      end
      ST_WRITE: begin
        state_d = ST_GAP;
      end
      ST_GAP: begin
        state_d = ST_ARB;
        if (!lockHeld) begin
          grant_d = '0;
        end
      end
      default: begin
        state_d = ST_ARB;
      end
    endcase
  end

  // State registers with synchronous reset back to idle arbitration at lane 0
  always_ff @(posedge clock) begin
    if (reset_i) begin
      state_q <= ST_ARB;
      ptr_q   <= '0;
      data_q  <= '0;
      grant_q <= '0;
`ifdef UART_TX_ARB_LOCK_EN
      lock_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      grant_q <= grant_d;
`ifdef UART_TX_ARB_LOCK_EN
      lock_q  <= lock_d;
`endif
    end
  end

  // Strobes are gated by reset so a byte sitting in WRITE is dropped rather than written
  assign bus.req_ready_o  = accept ? winOnehot : '0;
  assign bus.data_write_o = (state_q == ST_WRITE) && !reset_i;
  assign bus.data_o       = data_q;
  assign bus.grant_o      = grant_q;
  assign bus.busy_o       = (state_q != ST_ARB) || lockHeld;

  logic unusedWinLast;
  assign unusedWinLast = winLast;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized producer traffic,
// all compared cycle by cycle against a transaction-level reference model.
// Honours UART_TX_ARB_LOCK_EN the same way as the design.
module tb_uart_tx_arbiter;
  import uart_tx_arb_pkg::*;

  localparam int NUM_REQ = 4;

  logic clock;
  logic reset_i;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clock   (clock),
    .reset_i (reset_i),
    .bus     (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int assertCount = 0;
  int failCount   = 0;

  // Producer queues: {last, data} per pending byte on each lane
  logic [8:0] laneQ [NUM_REQ][$];
  logic       fullDrive;
  logic [7:0] dutLog [$];

  // Reference model: pointer, lock owner, cycles since last accept, last byte and winner
  int         mPtr;
  int         mOwner;
  int         mSince;
  int         mLast;
  int         mWrites;
  logic [7:0] mData;

  logic [NUM_REQ-1:0] expReady;
  logic [NUM_REQ-1:0] expGrant;
  logic               expWrite;
  logic               expBusy;
  int                 expWin;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus();
    logic [NUM_REQ-1:0]   v;
    logic [NUM_REQ-1:0]   l;
    logic [NUM_REQ*8-1:0] d;
    v = '0;
    l = '0;
    d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (laneQ[i].size() > 0) begin
        v[i]          = 1'b1;
        l[i]          = laneQ[i][0][8];
        d[i*8 +: 8]   = laneQ[i][0][7:0];
      end else begin
        l[i]          = 1'($urandom_range(0, 1));
        d[i*8 +: 8]   = 8'($urandom_range(0, 255));
      end
    end
    bus.req_valid_i        = v;
    bus.req_last_i         = l;
    bus.req_data_i         = d;
    bus.data_buffer_full_i = fullDrive;
  endtask

  task automatic modelReset();
    mPtr   = 0;
    mOwner = -1;
    mSince = 3;
    mLast  = 0;
    mData  = 8'h00;
  endtask

  // Expected outputs for the current cycle, derived from the arbitration rules
  task automatic computeExpect();
    expWin   = -1;
    expReady = '0;
    if (mSince >= 3 && !reset_i && !fullDrive) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        int c;
        c = (mPtr + k) % NUM_REQ;
        if (expWin < 0 && laneQ[c].size() > 0 && (mOwner < 0 || mOwner == c)) begin
          expWin = c;
        end
      end
    end
    if (expWin >= 0) expReady = NUM_REQ'(1) << expWin;
    expWrite = (mSince == 1) && !reset_i;
    if (mSince == 1 || mSince == 2) expGrant = NUM_REQ'(1) << mLast;
    else if (mOwner >= 0)           expGrant = NUM_REQ'(1) << mOwner;
    else                            expGrant = '0;
    expBusy = (mSince < 3) || (mOwner >= 0);
  endtask

  task automatic updateModel();
    logic [8:0] head;
    if (reset_i) begin
      modelReset();
    end else if (expWin >= 0) begin
      head  = laneQ[expWin].pop_front();
      mData = head[7:0];
      mLast = expWin;
`ifdef UART_TX_ARB_LOCK_EN
      if (head[8]) begin
        mOwner = -1;
        mPtr   = (expWin + 1) % NUM_REQ;
      end else begin
        mOwner = expWin;
      end
`else
      mPtr  = (expWin + 1) % NUM_REQ;
`endif
      mSince = 1;
    end else if (mSince < 3) begin
      mSince++;
    end
  endtask

  task automatic runCycle();
    applyStimulus();
    @(negedge clock);
    computeExpect();
    if (expWrite) mWrites++;
    checkOutput("ready", 32'(bus.req_ready_o), 32'(expReady));
    checkOutput("write", 32'(bus.data_write_o), 32'(expWrite));
    checkOutput("data", 32'(bus.data_o), 32'(mData));
    checkOutput("grant", 32'(bus.grant_o), 32'(expGrant));
    checkOutput("busy", 32'(bus.busy_o), 32'(expBusy));
    if (bus.data_write_o === 1'b1) dutLog.push_back(bus.data_o);
    @(posedge clock);
    updateModel();
    #1;
  endtask

  task automatic runN(input int n);
    for (int i = 0; i < n; i++) runCycle();
  endtask

  task automatic resetDut();
    for (int i = 0; i < NUM_REQ; i++) laneQ[i].delete();
    fullDrive = 1'b0;
    reset_i   = 1'b1;
    runCycle();
    reset_i   = 1'b0;
    dutLog.delete();
    mWrites   = 0;
  endtask

  initial begin
    reset_i   = 1'b1;
    fullDrive = 1'b0;
    mWrites   = 0;
    modelReset();
    applyStimulus();
    @(posedge clock);
    #1;
    resetDut();

    $display("[TB] single requester");
    laneQ[0].push_back({1'b1, 8'h55});
    runN(4);
    checkOutput("single_cnt", 32'(dutLog.size()), 32'd1);
    checkOutput("single_b0", 32'(dutLog[0]), 32'h55);

    $display("[TB] round robin");
    resetDut();
    laneQ[0].push_back({1'b1, 8'hA0});
    laneQ[1].push_back({1'b1, 8'hB1});
    laneQ[2].push_back({1'b1, 8'hC2});
    runN(10);
    checkOutput("rr_cnt", 32'(dutLog.size()), 32'd3);
    checkOutput("rr_b0", 32'(dutLog[0]), 32'hA0);
    checkOutput("rr_b1", 32'(dutLog[1]), 32'hB1);
    checkOutput("rr_b2", 32'(dutLog[2]), 32'hC2);
    laneQ[0].push_back({1'b1, 8'h30});
    laneQ[3].push_back({1'b1, 8'h33});
    runN(7);
    checkOutput("rr_ptr3_b0", 32'(dutLog[3]), 32'h33);
    checkOutput("rr_ptr3_b1", 32'(dutLog[4]), 32'h30);

    $display("[TB] backpressure");
    resetDut();
    fullDrive = 1'b1;
    laneQ[1].push_back({1'b1, 8'h5A});
    runN(10);
    checkOutput("bp_nowrite", 32'(dutLog.size()), 32'd0);
    fullDrive = 1'b0;
    runN(4);
    checkOutput("bp_cnt", 32'(dutLog.size()), 32'd1);
    checkOutput("bp_b0", 32'(dutLog[0]), 32'h5A);

    $display("[TB] packet lock");
    resetDut();
    laneQ[0].push_back({1'b0, 8'h01});
    laneQ[0].push_back({1'b1, 8'h02});
    laneQ[1].push_back({1'b1, 8'hFF});
    runN(12);
    checkOutput("lock_cnt", 32'(dutLog.size()), 32'd3);
    checkOutput("lock_b0", 32'(dutLog[0]), 32'h01);
`ifdef UART_TX_ARB_LOCK_EN
    checkOutput("lock_b1", 32'(dutLog[1]), 32'h02);
    checkOutput("lock_b2", 32'(dutLog[2]), 32'hFF);
`else
    checkOutput("lock_b1", 32'(dutLog[1]), 32'hFF);
    checkOutput("lock_b2", 32'(dutLog[2]), 32'h02);
`endif

    $display("[TB] reset during write");
    resetDut();
    laneQ[2].push_back({1'b1, 8'h77});
    runCycle();
    reset_i = 1'b1;
    runCycle();
    reset_i = 1'b0;
    laneQ[0].push_back({1'b1, 8'h10});
    laneQ[3].push_back({1'b1, 8'h33});
    runN(8);
    checkOutput("rst_cnt", 32'(dutLog.size()), 32'd2);
    checkOutput("rst_b0", 32'(dutLog[0]), 32'h10);
    checkOutput("rst_b1", 32'(dutLog[1]), 32'h33);

    $display("[TB] random traffic");
    resetDut();
    for (int cyc = 0; cyc < 600; cyc++) begin
      if ($urandom_range(0, 5) == 0) begin
        int lane;
        int len;
        lane = int'($urandom_range(0, NUM_REQ - 1));
        len  = int'($urandom_range(1, 3));
        for (int b = 0; b < len; b++) begin
          laneQ[lane].push_back({(b == len - 1), 8'($urandom_range(0, 255))});
        end
      end
      fullDrive = ($urandom_range(0, 3) == 0);
      runCycle();
    end
    fullDrive = 1'b0;
    runN(150);
    begin
      int pending;
      pending = 0;
      for (int i = 0; i < NUM_REQ; i++) pending += laneQ[i].size();
      checkOutput("rand_drain", 32'(pending), 32'd0);
    end
    checkOutput("rand_cnt", 32'(dutLog.size()), 32'(mWrites));

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
